alu_req_sched: RTL and testbench
================================

# alu_req_sched

Request scheduler and sequencer in front of the 4-bit ALU. Two independent requesters share the single ALU through round-robin arbitration; the block latches the granted operation, drives the ALU select and operand inputs, and waits out the ALU's registered latency. It then returns the 4-bit result plus carry, with an error flag, over a valid/ready response port. The block sits between the command-issuing logic and the ALU datapath. It is the only driver of the ALU inputs.

## Interface
- ALU_LATENCY, 1, clock edges from stable ALU inputs to valid alu_out/alu_carry; legal 0..3
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  bit i = requester i has an operation pending
- req_ready  out  2  bit i = requester i's operation accepted this cycle
- req0_a, req0_b  in  4 each  requester 0 operands
- req0_op  in  4  requester 0 ALU select
- req1_a, req1_b  in  4 each  requester 1 operands
- req1_op  in  4  requester 1 ALU select
- alu_a, alu_b  out  4 each  registered operands to ALU
- alu_sel  out  4  registered select to ALU
- alu_out  in  4  ALU result
- alu_carry  in  1  ALU carry/high bit
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester the response belongs to
- rsp_result  out  4  captured result
- rsp_carry  out  1  captured carry
- rsp_err  out  1  operation rejected, not executed
- busy  out  1  state != IDLE
- done_count  out  8  completed responses, wraps 255 -> 0

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset (reset_n=0, async) clears the following: all outputs 0; alu_a/alu_b/alu_sel=0; last_grant=1; cnt=0; done_count=0. An in-flight operation or held response is discarded.
- Arbitration in IDLE:
  - If only one req_valid bit is set, that requester is granted.
  - If both are set, the requester != last_grant is granted. After reset, requester 0 wins the first tie.
- req_ready[i] is combinational: (state==IDLE) && grant==i. It is never asserted outside IDLE. At most one bit is set.
- Accept edge, when req_valid[g] && req_ready[g]:
  - latch rsp_id=g and last_grant=g;
  - load alu_a, alu_b, alu_sel from requester g;
  - set cnt=0.
- Legal ops: 4'b0000 add, 0001 sub, 0010 mul, 0011 div.
- Reject path:
  - Reject when op > 4'b0011, or when op==0011 and b==0.
  - On accept, go directly to RESP with rsp_err=1, rsp_result=0, rsp_carry=0.
  - alu_* are still loaded but their result is ignored.
- EXEC:
  - cnt increments each cycle.
  - When cnt==ALU_LATENCY, capture rsp_result=alu_out and rsp_carry=alu_carry, set rsp_err=0, go to RESP.
- Results pass through unmodified. The block does no width or sign adjustment: sub borrow and mul/div high bit arrive on alu_carry.
- RESP:
  - rsp_valid=1; rsp_* are stable until handshake.
  - On rsp_valid && rsp_ready, go to IDLE, clear rsp_valid, and increment done_count (including rejects).
- alu_a/alu_b/alu_sel hold their last value outside EXEC. They change only on an accept edge.
- Requesters must hold operands and op stable while req_valid=1 and not yet accepted. req_valid may deassert before acceptance without effect.

## Timing
- Accept in cycle 0 → EXEC in cycles 1..ALU_LATENCY+1 → rsp_valid in cycle ALU_LATENCY+2. With the default, rsp_valid rises 3 cycles after accept.
- Reject: rsp_valid in cycle 1.
- A response handshake in cycle n returns to IDLE in n+1. The next accept is possible in cycle n+1, so there is no back-to-back accept without one IDLE cycle.
- Minimum issue interval with rsp_ready held high: ALU_LATENCY+3 cycles.
- rsp_ready low: stay in RESP indefinitely. No new accept occurs and req_ready stays 0.
- reset_n asserted mid-EXEC or mid-RESP: outputs clear asynchronously. First accept is possible in the first cycle after deassertion.

## Test plan
- Reset then req0: a=3, b=5, op=0000 → req_ready[0] in cycle 0; alu_sel=0000 from cycle 1; rsp_valid at cycle 3 with id=0, result=8, carry=0, err=0; done_count=1.
- Both valid and held, rsp_ready=1: req0 op 0001 a=2 b=3, req1 op 0010 a=4 b=5 → grant order 0,1,0,1; req1 response result=4, carry=1 (20=5'b10100).
- req1 op=0011 a=9 b=0 → rsp_valid cycle 1 with id=1, err=1, result=0, carry=0; alu_out ignored.
- req0 op=1010 → rejected with err=1; req1 pending at the same time is served next with correct id.
- rsp_ready held 0 for 10 cycles during RESP → rsp_* stable, req_ready=00, busy=1; release gives one handshake and done_count+1.
- reset_n pulsed low in EXEC → rsp_valid=0, busy=0, done_count=0 immediately. The next request completes normally, and requester 0 wins the first tie.

Source files
------------

// File: rtl/alu_req_sched.sv
// -----------------------------------------------------------------------------
// alu_req_sched
//   Round-robin request scheduler in front of the 4-bit ALU. Two requesters
//   share the ALU. The granted operation is latched onto the ALU inputs. The
//   block waits out the ALU's registered latency and then holds the
//   result/carry (or a reject) on a valid/ready response port.
//
// Ports
//   clock_i, reset_n_i     clock, asynchronous active-low reset
//   req_valid_i[1:0]       requester i has an operation pending
//   req_ready_o[1:0]       requester i's operation accepted this cycle
//   req{0,1}_{a,b,op}_i    requester operands and ALU select
//   alu_a_o/alu_b_o/alu_sel_o  registered ALU inputs (change only on accept)
//   alu_out_i, alu_carry_i ALU result and carry/high bit
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_id_o, rsp_result_o, rsp_carry_o, rsp_err_o  held response fields
//   busy_o                 scheduler not idle
//   done_count_o           completed responses (wraps)
// -----------------------------------------------------------------------------
module alu_req_sched #(
    parameter int ALU_LATENCY = 1   // 0..3
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic [1:0] req_valid_i,
    output logic [1:0] req_ready_o,
    input  logic [3:0] req0_a_i,
    input  logic [3:0] req0_b_i,
    input  logic [3:0] req0_op_i,
    input  logic [3:0] req1_a_i,
    input  logic [3:0] req1_b_i,
    input  logic [3:0] req1_op_i,
    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    output logic [3:0] alu_sel_o,
    input  logic [3:0] alu_out_i,
    input  logic       alu_carry_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic       rsp_id_o,
    output logic [3:0] rsp_result_o,
    output logic       rsp_carry_o,
    output logic       rsp_err_o,
    output logic       busy_o,
    output logic [7:0] done_count_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
    } req_t;

    localparam logic [1:0] LAT = 2'(ALU_LATENCY);

    state_e     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [3:0] alu_sel_q, alu_sel_d;
    logic       rsp_id_q, rsp_id_d;
    logic [3:0] rsp_result_q, rsp_result_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] done_q, done_d;

    req_t req0, req1, req_g;
    logic grant;      // requester index chosen this cycle
    logic accept;     // an operation is taken this cycle
    logic reject;     // granted op is illegal or divides by zero
    logic exec_done;  // ALU output is valid this cycle
    logic rsp_fire;

    assign req0 = {req0_a_i, req0_b_i, req0_op_i};
    assign req1 = {req1_a_i, req1_b_i, req1_op_i};

    // Grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant     = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];
        req_g     = grant ? req1 : req0;
        accept    = (state_q == IDLE) && (req_valid_i != 2'b00);
        reject    = (req_g.op > 4'd3) || ((req_g.op == 4'd3) && (req_g.b == 4'd0));
        exec_done = (state_q == EXEC) && (cnt_q == LAT);
        rsp_fire  = (state_q == RESP) && rsp_ready_i;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = reject ? RESP : EXEC;
            EXEC:    if (exec_done) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready_o = 2'b00;
        if (accept) req_ready_o = grant ? 2'b10 : 2'b01;
        rsp_valid_o = (state_q == RESP);
        busy_o      = (state_q != IDLE);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        done_d       = done_q;

        if (accept) begin
            last_grant_d = grant;
            rsp_id_d     = grant;
            // ALU inputs load even on reject; its result is simply never captured.
            alu_a_d      = req_g.a;
            alu_b_d      = req_g.b;
            alu_sel_d    = req_g.op;
            cnt_d        = 2'd0;
            if (reject) begin
                rsp_err_d    = 1'b1;
                rsp_result_d = 4'd0;
                rsp_carry_d  = 1'b0;
            end
        end

        if (state_q == EXEC) begin
            cnt_d = cnt_q + 2'd1;
            if (exec_done) begin
                rsp_result_d = alu_out_i;
                rsp_carry_d  = alu_carry_i;
                rsp_err_d    = 1'b0;
            end
        end

        if (rsp_fire) done_d = done_q + 8'd1;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_q <= 1'b1;  // requester 0 wins the first tie
            cnt_q        <= 2'd0;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            alu_sel_q    <= 4'd0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 4'd0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            done_q       <= 8'd0;
        end else begin
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
            done_q       <= done_d;
        end
    end

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_sel_o    = alu_sel_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_carry_o  = rsp_carry_q;
    assign rsp_err_o    = rsp_err_q;
    assign done_count_o = done_q;

endmodule

// File: tb/tb_alu_req_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_req_sched
//   Directed scenarios with literal expectations, then randomized traffic.
//   A transaction-level model (grant rule, countdown to response, expected
//   result from plain arithmetic) is compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_alu_req_sched;
    localparam int L = 1;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [3:0] ra [2];
    logic [3:0] rb [2];
    logic [3:0] rop[2];
    logic       rsp_ready = 1'b1;
    logic [3:0] alu_out = 4'd0;
    logic       alu_carry = 1'b0;

    wire [1:0] req_ready;
    wire [3:0] alu_a, alu_b, alu_sel, rsp_result;
    wire       rsp_valid, rsp_id, rsp_carry, rsp_err, busy;
    wire [7:0] done_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    alu_req_sched #(.ALU_LATENCY(L)) dut (
        .clock_i(clock), .reset_n_i(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req0_a_i(ra[0]), .req0_b_i(rb[0]), .req0_op_i(rop[0]),
        .req1_a_i(ra[1]), .req1_b_i(rb[1]), .req1_op_i(rop[1]),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
        .alu_out_i(alu_out), .alu_carry_i(alu_carry),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_result_o(rsp_result), .rsp_carry_o(rsp_carry),
        .rsp_err_o(rsp_err), .busy_o(busy), .done_count_o(done_count)
    );

    // {carry, result} of the arithmetic the ALU performs
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] op);
        logic [7:0] p;
        case (op)
            4'd0: return {1'b0, a} + {1'b0, b};
            4'd1: return {1'b0, a} - {1'b0, b};
            4'd2: begin p = {4'd0, a} * {4'd0, b}; return p[4:0]; end
            4'd3: return (b == 4'd0) ? 5'h1F : {1'b0, a / b};
            default: return 5'h15;
        endcase
    endfunction

    // ALU stand-in with one registered stage; junk for unsupported selects
    always @(posedge clock) begin
        if (alu_sel > 4'd3) {alu_carry, alu_out} <= 5'($urandom);
        else                {alu_carry, alu_out} <= alu_fn(alu_a, alu_b, alu_sel);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit       m_busy;
    int       m_timer;     // cycles left before the response shows
    bit       m_last;
    bit [7:0] m_done;
    bit       m_id, m_err, m_car;
    bit [3:0] m_res, m_a, m_b, m_sel;

    always @(negedge clock) begin
        logic       g;
        logic [1:0] er;
        logic [4:0] r;
        if (!reset_n) begin
            m_busy = 0; m_timer = 0; m_last = 1; m_done = 0;
            m_a = 0; m_b = 0; m_sel = 0;
        end
        g  = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        er = (!m_busy && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", req_ready, er);
        chk("busy", busy, m_busy);
        chk("rsp_valid", rsp_valid, m_busy && m_timer == 0);
        chk("done_count", done_count, m_done);
        chk("alu_in", {alu_a, alu_b, alu_sel}, {m_a, m_b, m_sel});
        if (m_busy && m_timer == 0)
            chk("rsp_fields", {rsp_id, rsp_err, rsp_carry, rsp_result},
                {m_id, m_err, m_car, m_res});
        if (reset_n) begin
            if (er != 2'b00) begin
                m_busy = 1; m_last = g; m_id = g;
                m_a = ra[g]; m_b = rb[g]; m_sel = rop[g];
                if (m_sel > 4'd3 || (m_sel == 4'd3 && m_b == 4'd0)) begin
                    m_err = 1; m_res = 0; m_car = 0; m_timer = 0;
                end else begin
                    r = alu_fn(m_a, m_b, m_sel);
                    m_err = 0; m_res = r[3:0]; m_car = r[4]; m_timer = L + 1;
                end
            end else if (m_busy) begin
                if (m_timer > 0) m_timer--;
                else if (rsp_ready) begin m_busy = 0; m_done++; end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        reset_n = 1'b0;
        #2;
        chk("reset_state", {req_ready, rsp_valid, busy, done_count, alu_a, alu_b, alu_sel,
                            rsp_id, rsp_result, rsp_carry, rsp_err}, 0);
        tick(); tick();
        reset_n = 1'b1;
    endtask

    // Called in cycle 1 after an accept; returns the cycle rsp_valid shows.
    task automatic wait_rsp(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (rsp_valid) begin cyc = c; return; end
            tick();
        end
        chk("rsp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (!busy) begin tick(); return; end
            tick();
        end
        chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int cyc, n, d0;
        int order[4];
        bit seen0, seen1;
        logic [1:0] acc;
        for (int i = 0; i < 2; i++) begin ra[i] = 0; rb[i] = 0; rop[i] = 0; end

        // T1: single add after reset
        do_reset();
        ra[0] = 3; rb[0] = 5; rop[0] = 0; req_valid = 2'b01;
        @(negedge clock); chk("t1_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        chk("t1_alu_in", {alu_a, alu_b, alu_sel}, {4'd3, 4'd5, 4'd0});
        wait_rsp(cyc);
        chk("t1_latency", cyc, 3);
        chk("t1_rsp", {rsp_id, rsp_err, rsp_carry, rsp_result}, {1'b0, 1'b0, 1'b0, 4'd8});
        tick();
        @(negedge clock); chk("t1_done", done_count, 1);
        tick();

        // T2: both held, alternation 0,1,0,1
        do_reset();
        ra[0] = 2; rb[0] = 3; rop[0] = 1; ra[1] = 4; rb[1] = 5; rop[1] = 2;
        req_valid = 2'b11; n = 0; seen0 = 0; seen1 = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clock);
            if (rsp_valid && rsp_id && !seen1) begin
                seen1 = 1;
                chk("t2_mul", {rsp_err, rsp_carry, rsp_result}, {1'b0, 1'b1, 4'd4});
            end
            if (rsp_valid && !rsp_id && !seen0) begin
                seen0 = 1;
                chk("t2_sub", {rsp_err, rsp_carry, rsp_result}, {1'b0, 1'b1, 4'hF});
            end
            if (req_ready != 2'b00) begin order[n] = int'(req_ready[1]); n++; end
            tick();
        end
        req_valid = 2'b00;
        chk("t2_n", n, 4);
        chk("t2_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
        chk("t2_seen", {seen0, seen1}, 2'b11);
        wait_idle();

        // T3: divide by zero rejected
        ra[1] = 9; rb[1] = 0; rop[1] = 3; req_valid = 2'b10;
        @(negedge clock); chk("t3_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        wait_rsp(cyc);
        chk("t3_latency", cyc, 1);
        chk("t3_rsp", {rsp_id, rsp_err, rsp_carry, rsp_result}, {1'b1, 1'b1, 1'b0, 4'd0});
        tick();

        // T4: illegal op from req0, req1 waiting
        ra[0] = 0; rb[0] = 0; rop[0] = 4'b1010; ra[1] = 1; rb[1] = 1; rop[1] = 0;
        req_valid = 2'b11;
        @(negedge clock); chk("t4_ready0", req_ready, 2'b01);
        tick(); req_valid = 2'b10;
        wait_rsp(cyc);
        chk("t4_rej", {rsp_id, rsp_err, rsp_carry, rsp_result}, {1'b0, 1'b1, 1'b0, 4'd0});
        tick();
        @(negedge clock); chk("t4_ready1", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        wait_rsp(cyc);
        chk("t4_rsp1", {rsp_id, rsp_err, rsp_carry, rsp_result}, {1'b1, 1'b0, 1'b0, 4'd2});
        tick();

        // T5: back-pressure holds the response
        rsp_ready = 1'b0;
        ra[0] = 7; rb[0] = 9; rop[0] = 0; req_valid = 2'b01;
        @(negedge clock); chk("t5_ready", req_ready, 2'b01);
        tick(); ra[1] = 2; rb[1] = 2; rop[1] = 0; req_valid = 2'b10;
        wait_rsp(cyc);
        chk("t5_rsp", {rsp_id, rsp_err, rsp_carry, rsp_result}, {1'b0, 1'b0, 1'b1, 4'd0});
        d0 = int'(done_count);
        for (int c = 0; c < 10; c++) begin
            tick(); @(negedge clock);
            chk("t5_hold", {rsp_valid, rsp_id, rsp_err, rsp_carry, rsp_result, req_ready, busy},
                {1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 2'b00, 1'b1});
        end
        tick(); rsp_ready = 1'b1;
        tick();
        @(negedge clock);
        chk("t5_done", done_count, (d0 + 1) & 255);
        chk("t5_next", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        wait_rsp(cyc); tick();

        // T6: reset in EXEC
        ra[0] = 1; rb[0] = 2; rop[0] = 0; req_valid = 2'b01;
        tick(); req_valid = 2'b00;
        reset_n = 1'b0; #1;
        chk("t6_reset", {rsp_valid, busy, done_count, alu_a}, 0);
        tick(); reset_n = 1'b1;
        ra[0] = 5; rb[0] = 6; rop[0] = 0; ra[1] = 3; rb[1] = 3; rop[1] = 1;
        req_valid = 2'b11;
        @(negedge clock); chk("t6_tie", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        wait_rsp(cyc);
        chk("t6_latency", cyc, 3);
        chk("t6_rsp", {rsp_id, rsp_err, rsp_carry, rsp_result}, {1'b0, 1'b0, 1'b0, 4'd11});
        tick();
        @(negedge clock); chk("t6_done", done_count, 1);
        tick();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            acc = req_valid & req_ready;
            tick();
            req_valid = req_valid & ~acc;
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        ra[i]  = 4'($urandom);
                        rb[i]  = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
                        rop[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15))
                                                             : 4'($urandom_range(0, 3));
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 40) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 2'b00; rsp_ready = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
